// File: rtl/gray_pkg.sv
// gray_pkg: shared widths and state encoding for the 2x2 grayscale downscaler
package gray_pkg;
  localparam int GRAY_W = 10;
  localparam int PAIR_W = 11;
  localparam int QUAD_W = 12;
  typedef enum logic [1:0] {WAIT_SOF, EVEN_ROW, ODD_ROW} state_t;
endpackage

// File: rtl/gray_line_buffer.sv
// gray_line_buffer: simple dual-port line buffer of pair sums, one write port and one async read port
module gray_line_buffer
  import gray_pkg::*;
#(
  parameter int DEPTH = 320,
  parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [PAIR_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [PAIR_W-1:0] rdata
);
  logic [PAIR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/gray_downscale_2x2.sv
// gray_downscale_2x2: 2x2 box-average grayscale downscaler with ready/valid handshake; GRAY_DS_ROUND_EN selects round-half-up over truncation
module gray_downscale_2x2
  import gray_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GRAY_W-1:0] gray_in,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [GRAY_W-1:0] gray_out,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  input  logic              out_ready
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int DEPTH = IMG_WIDTH / 2;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef GRAY_DS_ROUND_EN
  localparam logic [QUAD_W-1:0] RND = QUAD_W'(2);
`else
  localparam logic [QUAD_W-1:0] RND = '0;
`endif
  state_t state;
  logic [CW-1:0] col, c;
  logic [RW-1:0] row, r;
  logic [GRAY_W-1:0] pix0;
  logic [PAIR_W-1:0] pair, line_q;
  logic [QUAD_W-1:0] quad;
  logic accept, proc, odd, last_col, last_row;
  assign in_ready = !(out_valid && !out_ready);
  assign accept = in_valid && in_ready;
  assign proc = accept && (in_sof || state != WAIT_SOF);
  assign c = in_sof ? '0 : col;
  assign r = in_sof ? '0 : row;
  assign odd = !in_sof && state == ODD_ROW;
  assign last_col = c == CW'(IMG_WIDTH - 1);
  assign last_row = r == RW'(IMG_HEIGHT - 1);
  assign pair = PAIR_W'(pix0) + PAIR_W'(gray_in);
  assign quad = QUAD_W'(pair) + QUAD_W'(line_q) + RND;
  gray_line_buffer #(.DEPTH(DEPTH), .AW(AW)) u_line (
    .clk   (clk),
    .we    (proc && c[0] && !odd),
    .waddr (AW'(c >> 1)),
    .wdata (pair),
    .raddr (AW'(c >> 1)),
    .rdata (line_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_SOF;
      col       <= '0;
      row       <= '0;
      pix0      <= '0;
      out_valid <= 1'b0;
      gray_out  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (proc) begin
        if (!c[0]) pix0 <= gray_in;
        col   <= last_col ? '0 : c + CW'(1);
        row   <= !last_col ? r : last_row ? '0 : r + RW'(1);
        state <= (last_col && last_row) ? WAIT_SOF : ((last_col ? !odd : odd) ? ODD_ROW : EVEN_ROW);
        if (c[0] && odd) begin
          out_valid <= 1'b1;
          gray_out  <= GRAY_W'(quad >> 2);
          out_sof   <= c == CW'(1) && r == RW'(1);
          out_eol   <= last_col;
        end
      end
    end
  end
endmodule

// File: tb/tb_gray_downscale_2x2.sv
// tb_gray_downscale_2x2: scoreboard bench for the 2x2 downscaler on a 4x2 frame
module tb_gray_downscale_2x2;
  localparam int W = 4;
  localparam int H = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] gray_in = '0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic in_ready;
  logic [9:0] gray_out;
  logic out_valid, out_sof, out_eol;
  logic out_ready = 1'b1;
  gray_downscale_2x2 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .gray_out  (gray_out),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_ready (out_ready)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  typedef struct {int g; int sof; int eol;} exp_t;
  exp_t q[$];
  int m_on = 0;
  int m_col = 0;
  int m_row = 0;
  int top[W];
  int bot[W];
  function automatic int avg4(int s);
`ifdef GRAY_DS_ROUND_EN
    return (s + 2) / 4;
`else
    return s / 4;
`endif
  endfunction
  task automatic model_pix(int p, bit sof);
    exp_t e;
    if (sof) begin
      m_on = 1;
      m_col = 0;
      m_row = 0;
    end
    if (m_on == 0) return;
    if (m_row % 2 == 0) top[m_col] = p;
    else begin
      bot[m_col] = p;
      if (m_col % 2 == 1) begin
        e.g = avg4(top[m_col-1] + top[m_col] + bot[m_col-1] + bot[m_col]);
        e.sof = (m_row == 1 && m_col == 1) ? 1 : 0;
        e.eol = (m_col == W - 1) ? 1 : 0;
        q.push_back(e);
      end
    end
    if (m_col == W - 1) begin
      m_col = 0;
      if (m_row == H - 1) begin
        m_row = 0;
        m_on = 0;
      end else m_row++;
    end else m_col++;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        check("gray_out", int'(gray_out), e.g);
        check("out_sof", int'(out_sof), e.sof);
        check("out_eol", int'(out_eol), e.eol);
      end
    end
  end
  task automatic send(int p, bit sof);
    int n = 0;
    bit acc = 1'b0;
    gray_in = 10'(p);
    in_sof = sof;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    if (acc) model_pix(p, sof);
    else check("accept_timeout", 0, 1);
  endtask
  task automatic send_frame(input int px[W*H]);
    for (int i = 0; i < W * H; i++) send(px[i], i == 0);
  endtask
  task automatic drain(string tag);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check(tag, q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_on = 0;
    m_col = 0;
    m_row = 0;
    q.delete();
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_gray_out", int'(gray_out), 0);
    check("rst_out_sof", int'(out_sof), 0);
    check("rst_out_eol", int'(out_eol), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask
  int f_basic[W*H] = '{100, 200, 300, 400, 101, 203, 305, 407};
  int f_round[W*H] = '{1, 1, 5, 5, 1, 0, 5, 6};
  int f_max[W*H] = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
  initial begin
    do_reset();
    send(7, 0);
    send(9, 0);
    send_frame(f_basic);
    drain("drain_basic");
    send_frame(f_round);
    drain("drain_round");
    send_frame(f_max);
    drain("drain_max");
    out_ready = 1'b0;
    fork
      send_frame(f_basic);
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_in_ready", int'(in_ready), 0);
          check("stall_hold", int'(gray_out), 151);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    send(10, 1);
    send(20, 0);
    send(50, 1);
    send(60, 0);
    send(70, 0);
    send(80, 0);
    send(51, 0);
    send(61, 0);
    send(71, 0);
    send(81, 0);
    drain("drain_restart");
    send(100, 1);
    send(200, 0);
    send(300, 0);
    send(400, 0);
    send(101, 0);
    send(203, 0);
    send(305, 0);
    do_reset();
    send(9, 0);
    send(9, 0);
    send(9, 0);
    drain("drain_after_rst");
    send_frame(f_basic);
    drain("drain_final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_downscale_2x2.md
GRAY_DOWNSCALE_2X2 -- requirements
Module: gray_downscale_2x2

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, input line length in pixels (even, >=2).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, input frame height in lines (even, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gray_in  input  10  grayscale pixel from the colour-to-grayscale stage.
REQ-006 SHALL have port in_valid  input  1  gray_in/in_sof valid.
REQ-007 SHALL have port in_sof  input  1  marks first pixel of a frame.
REQ-008 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have port gray_out  output  10  2x2 box-averaged pixel.
REQ-010 SHALL have port out_valid  output  1  gray_out valid.
REQ-011 SHALL have port out_sof  output  1  first output pixel of a frame.
REQ-012 SHALL have port out_eol  output  1  last output pixel of an output line.
REQ-013 SHALL have port out_ready  input  1  downstream accepts output.

Function
REQ-014 SHALL transfer input only when in_valid && in_ready, and output only when out_valid && out_ready.
REQ-015 SHALL drive in_ready = !(out_valid && !out_ready), i.e. stall only while holding an unaccepted output.
REQ-016 SHALL implement states WAIT_SOF, EVEN_ROW, ODD_ROW.
REQ-017 In WAIT_SOF, SHALL accept and discard pixels without in_sof; an accepted pixel with in_sof SHALL enter EVEN_ROW and be processed as column 0, row 0.
REQ-018 SHALL keep column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1), advanced per accepted pixel; column wraps to 0 at IMG_WIDTH-1 and advances the row.
REQ-019 EVEN_ROW: on odd column, SHALL write the 11-bit pair sum (pixel 2k + pixel 2k+1) into line-buffer entry k (IMG_WIDTH/2 entries).
REQ-020 ODD_ROW: on odd column, SHALL form the 12-bit sum of the pair sum and line-buffer entry k, and register gray_out = sum>>2 (rounding per REQ-030/031).
REQ-021 Latency: out_valid SHALL assert the cycle after the accepted pixel that completes a 2x2 block.
REQ-022 out_sof SHALL be 1 on output (0,0); out_eol SHALL be 1 on output column IMG_WIDTH/2-1; both are qualified by out_valid.
REQ-023 After the last pixel of row IMG_HEIGHT-1, SHALL return to WAIT_SOF.
REQ-024 An accepted in_sof in EVEN_ROW/ODD_ROW SHALL restart the frame: counters reset, pixel treated as (0,0), partial block data discarded, no output for the abandoned block.
REQ-025 Output registers SHALL hold value while out_valid && !out_ready.
REQ-026 Arithmetic SHALL not overflow: max sum 4092 (+2 rounding) fits 12 bits, result <=1023.

Reset
REQ-027 On rst, state SHALL be WAIT_SOF, counters 0, out_valid 0, gray_out 0, out_sof 0, out_eol 0.
REQ-028 in_ready SHALL be 1 in the cycle after reset.
REQ-029 Reset mid-frame SHALL discard all partial data; line-buffer contents need not be cleared.

Configuration
REQ-030 With macro GRAY_DS_ROUND_EN defined, gray_out SHALL be (sum+2)>>2 (round half up).
REQ-031 Without GRAY_DS_ROUND_EN, gray_out SHALL be sum>>2 (truncate).

Structure
REQ-032 Package gray_pkg SHALL hold GRAY_W=10, PAIR_W=11, QUAD_W=12 and the state enum.
REQ-033 Line buffer SHALL be sub-module gray_line_buffer (simple dual-port, 1 write/1 read, depth IMG_WIDTH/2, width PAIR_W).

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, out_ready=1 unless stated)
REQ-034 Frame rows 100,200,300,400 / 101,203,305,407 with in_sof on first -> outputs 151 (out_sof=1), 353 (out_eol=1).
REQ-035 Block 1,1 / 1,0 -> gray_out 1 with GRAY_DS_ROUND_EN, 0 without.
REQ-036 All pixels 1023 -> every output 1023, no wrap.
REQ-037 Hold out_ready=0 for 5 cycles at first output -> in_ready=0, gray_out stable at 151, no pixel lost; resumes correctly.
REQ-038 Pixels before in_sof dropped; second in_sof mid-row 0 -> restart, only new-frame outputs appear; rst mid-row 1 -> out_valid=0 next cycle, state WAIT_SOF.
